// File: rtl/pkt_tx.sv
// pkt_tx: SPI mode-0 packet transmitter, 1..NBYTES bytes per frame.
// Frames are MSB-first under an active-low load; load rising latches downstream.
module pkt_tx #(
  parameter int NBYTES = 2,
  parameter int DIV    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pkt_vld,
  output logic                         pkt_rdy,
  input  logic [8*NBYTES-1:0]          pkt,
  input  logic [$clog2(NBYTES+1)-1:0]  nbytes,
  output logic                         sclk,
  output logic                         sdo,
  output logic                         load,
  output logic                         busy,
  output logic                         done
);

  localparam int PW = 8 * NBYTES;
  localparam int NW = $clog2(NBYTES + 1);
  localparam int BW = $clog2(8 * NBYTES + 1);
  localparam int DW = $clog2(DIV + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] shreg_q, shreg_d;
  logic          sclk_q, sclk_d;
  logic          sdo_q, sdo_d;
  logic          load_q, load_d;
  logic          done_q, done_d;

  logic [NW-1:0] len_w;
  logic [BW-1:0] len_bits;
  logic [BW-1:0] pad_bits;
  logic [PW-1:0] aligned;
  logic          half_end;
  logic          last_bit;

  // Decode the requested length; 0 or oversize means a full packet
  always_comb begin
    len_w = nbytes;
    if (nbytes == '0 || nbytes > NW'(NBYTES)) begin
      len_w = NW'(NBYTES);
    end
    len_bits = BW'({len_w, 3'b000});
    pad_bits = BW'(PW) - len_bits;
    aligned  = pkt << pad_bits;
  end

  assign half_end = (div_cnt_q == DW'(DIV - 1));
  assign last_bit = (bit_cnt_q == BW'(1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      load_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      load_q    <= load_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pkt_vld) state_d = SHIFT;
      SHIFT: if (half_end && sclk_q && last_bit) state_d = HOLD;
      HOLD:  if (half_end) state_d = GAP;
      GAP:   if (half_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; the divider runs in every non-idle state
  always_comb begin
    div_cnt_d = half_end ? '0 : div_cnt_q + DW'(1);
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    load_d    = load_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        div_cnt_d = '0;
        if (pkt_vld) begin
          shreg_d   = aligned;
          bit_cnt_d = len_bits;
          sdo_d     = aligned[PW-1];
          sclk_d    = 1'b0;
          load_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (half_end) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q - BW'(1);
            shreg_d   = shreg_q << 1;
            sdo_d     = last_bit ? 1'b0 : shreg_q[PW-2];
          end
        end
      end
      HOLD: begin
        if (half_end) begin
          load_d = 1'b1;
          done_d = 1'b1;
        end
      end
      GAP: begin
        load_d = 1'b1;
      end
      default: begin
        div_cnt_d = '0;
      end
    endcase
  end

  assign sclk    = sclk_q;
  assign sdo     = sdo_q;
  assign load    = load_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);
  assign pkt_rdy = (state_q == IDLE) && !rst;

endmodule
